mem_port_arbiter: RTL

Shares the single external memory port of the pipelined RISC-V core between instruction fetch (IF) and the data access of the MEM stage. One transaction is outstanding at a time. Data has priority, with alternation when both requesters wait back-to-back. The block generates the stall signals that freeze the IF and MEM stages while their access is pending. It also discards a fetch response made stale by a taken branch or jump flush.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between instruction fetch and data
//            access; one outstanding transaction, data-first with alternation.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic [DATA_W-1:0]     if_rdata_o,
    output logic                  if_valid_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_W-1:0]     d_addr_i,
    input  logic [DATA_W-1:0]     d_wdata_i,
    input  logic [DATA_W/8-1:0]   d_be_i,
    output logic [DATA_W-1:0]     d_rdata_o,
    output logic                  d_valid_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic                  stall_if_o,
    output logic                  stall_mem_o
);

    localparam int         c_BE_W   = DATA_W / 8;
    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_REQ  = 2'd1;
    localparam logic [1:0] c_S_WAIT = 2'd2;
    localparam logic       c_OWN_IF = 1'b0;
    localparam logic       c_OWN_D  = 1'b1;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_owner;
    logic              r_last;
    logic              r_discard;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [c_BE_W-1:0] r_be;
    logic              w_grant_d;
    logic              w_grant_if;
    logic              w_complete;
    logic              w_if_valid;
    logic              w_d_valid;

    // State register plus owner, history, discard flag and latched command
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= c_S_IDLE;
            r_owner   <= c_OWN_IF;
            r_last    <= c_OWN_IF;
            r_discard <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_d) begin
                r_owner <= c_OWN_D;
                r_we    <= d_we_i;
                r_addr  <= d_addr_i;
                r_wdata <= d_wdata_i;
                r_be    <= d_be_i;
            end else if (w_grant_if) begin
                r_owner <= c_OWN_IF;
                r_we    <= 1'b0;
                r_addr  <= if_addr_i;
                r_wdata <= '0;
                r_be    <= '1;
            end
            // Completion wins over a same-cycle flush: the slot is finished either way
            if (w_complete) begin
                r_last    <= r_owner;
                r_discard <= 1'b0;
            end else if (flush_i && (r_owner == c_OWN_IF) && (r_state != c_S_IDLE)) begin
                r_discard <= 1'b1;
            end
        end
    end

    // Next-state and arbitration decision
    always_comb begin
        w_next_state = r_state;
        w_grant_d    = 1'b0;
        w_grant_if   = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (d_req_i && (!if_req_i || (r_last == c_OWN_IF))) begin
                    w_grant_d = 1'b1;
                end else if (if_req_i) begin
                    w_grant_if = 1'b1;
                end
                if (w_grant_d || w_grant_if) begin
                    w_next_state = c_S_REQ;
                end
            end
            c_S_REQ: begin
                if (mem_gnt_i) begin
                    w_next_state = c_S_WAIT;
                end
            end
            c_S_WAIT: begin
                if (mem_rvalid_i) begin
                    w_complete   = 1'b1;
                    w_next_state = c_S_IDLE;
                end
            end
            default: w_next_state = c_S_IDLE;
        endcase
    end

    // Outputs; rdata is forced to zero outside its valid pulse
    always_comb begin
        w_if_valid  = (r_state == c_S_WAIT) && mem_rvalid_i && (r_owner == c_OWN_IF) && !r_discard;
        w_d_valid   = (r_state == c_S_WAIT) && mem_rvalid_i && (r_owner == c_OWN_D);
        mem_req_o   = (r_state == c_S_REQ);
        mem_we_o    = r_we;
        mem_addr_o  = r_addr;
        mem_wdata_o = r_wdata;
        mem_be_o    = r_be;
        if_valid_o  = w_if_valid;
        d_valid_o   = w_d_valid;
        if_rdata_o  = w_if_valid ? mem_rdata_i : '0;
        d_rdata_o   = w_d_valid ? mem_rdata_i : '0;
        stall_if_o  = if_req_i & ~w_if_valid;
        stall_mem_o = d_req_i & ~w_d_valid;
    end

endmodule
`default_nettype wire
